// File: rtl/ps2_kb_rx_if.sv
// Event stream from the PS/2 keyboard receiver: head-of-FIFO data, valid/ready
// handshake and FIFO occupancy.
interface ps2_kb_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [9:0]    ev_data;
  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_count;

  modport master (
    output ev_data,
    output ev_valid,
    output ev_count,
    input  ev_ready
  );

  modport slave (
    input  ev_data,
    input  ev_valid,
    input  ev_count,
    output ev_ready
  );
endinterface

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the PS/2 lines, deframe
// 11-bit frames, fold E0/F0 prefixes into flags and queue {ext, brk, code}.
module ps2_kb_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_kb,
  input  logic         data_kb,
  ps2_kb_rx_if.master  ev,
  output logic         err_frame,
  output logic         err_timeout,
  output logic         err_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  // ---- stage p0/p1: two-flop synchronisers, idle-high
  logic clk_kb_p0, clk_kb_p1, data_kb_p0, data_kb_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_kb_p0  <= 1'b1;
      clk_kb_p1  <= 1'b1;
      data_kb_p0 <= 1'b1;
      data_kb_p1 <= 1'b1;
    end else begin
      clk_kb_p0  <= clk_kb;
      clk_kb_p1  <= clk_kb_p0;
      data_kb_p0 <= data_kb;
      data_kb_p1 <= data_kb_p0;
    end
  end

  // ---- glitch filter and falling-edge strobe
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_kb_p1 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_kb_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strobe = filt_prev & ~filt_clk;

  // ---- frame FSM
  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          byte_ok, frame_err, to_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    to_d      = '0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    to_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (!data_kb_p1) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          sh_d  = {data_kb_p1, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_d   = odd_parity_ok(sh_q, data_kb_p1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (data_kb_p1 && par_q) byte_ok = 1'b1;
          else                     frame_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A stalled frame is abandoned; the decoder prefix flags are left alone.
    if (state_q != IDLE && !strobe) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        bit_d   = '0;
        to_err  = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  // ---- stage p0: received byte, then prefix decode
  logic       byte_vld_p0;
  logic [7:0] byte_p0;
  logic       ext_q, brk_q;
  logic       push;
  logic [9:0] push_data;

  always_ff @(posedge clk) begin
    byte_p0 <= sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_vld_p0 <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      byte_vld_p0 <= byte_ok;
      if (byte_vld_p0) begin
        if (byte_p0 == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_p0 == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign push      = byte_vld_p0 && (byte_p0 != 8'hE0) && (byte_p0 != 8'hF0);
  assign push_data = {ext_q, brk_q, byte_p0};

  // ---- event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          full, pop_en, wr_en, drop;

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop_en = (count_q != '0) && ev.ev_ready;
  assign wr_en  = push && (!full || pop_en);
  assign drop   = push && full && !pop_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      err_frame   <= frame_err;
      err_timeout <= to_err;
      err_ovf     <= drop;
    end
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_count = count_q;
  assign ev.ev_data  = (count_q != '0) ? mem[rd_ptr] : '0;

endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of event entries buffered (power of two, 2..64).
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning the number of consecutive equal clk samples needed to accept a new ps2 clock level.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the maximum number of clk cycles between ps2 falling edges inside a frame.
REQ-004 Port clk, input, 1 bit: system clock, with all logic on posedge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port clk_kb, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-007 Port data_kb, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-008 Port ev_data, output, 10 bits: {ext, brk, code[7:0]} at the FIFO head.
REQ-009 Port ev_valid, output, 1 bit: the FIFO is not empty.
REQ-010 Port ev_ready, input, 1 bit: consumer accept.
REQ-011 Port ev_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 Port err_frame, output, 1 bit: one-cycle pulse on a start, parity or stop error.
REQ-013 Port err_timeout, output, 1 bit: one-cycle pulse on a frame timeout.
REQ-014 Port err_ovf, output, 1 bit: one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 clk_kb and data_kb SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 Filtered ps2 clock SHALL change level only after FILTER_LEN consecutive synchronized samples differ from its current level; it resets to 1.
REQ-017 A falling edge of the filtered clock SHALL produce a one-cycle sample strobe; synchronized data is captured on the strobe.
REQ-018 The frame FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0, go to DATA with bit index 0. On strobe with data=1 (bad start), stay in IDLE and pulse err_frame.
  - DATA: on each strobe, shift the bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on strobe, latch parity. Parity is OK when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: on strobe, go to IDLE. If stop=1 and parity is OK, the byte is valid. Otherwise pulse err_frame and discard the byte.
REQ-019 Timeout counter SHALL clear on every strobe and in IDLE. When it reaches TIMEOUT_CYC in any non-IDLE state, the FSM goes to IDLE, pulses err_timeout and discards the partial byte. Decoder flags are not changed.
REQ-020 Decoder handling of a valid byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and then clears ext and brk.
  - 0xE0 and 0xF0 alone never push.
REQ-021 Latency: the push SHALL occur 1 clk cycle after the STOP strobe, and ev_valid SHALL be high on the following cycle if the FIFO was empty.
REQ-022 Pop SHALL occur on the clk edge where ev_valid && ev_ready. ev_data SHALL be stable while ev_valid && !ev_ready.
REQ-023 A push when the FIFO is full and no pop happens in the same cycle SHALL drop the event and pulse err_ovf. A push and pop in the same cycle when full SHALL succeed.
REQ-024 A simultaneous push and pop SHALL leave ev_count unchanged. Pointers wrap modulo FIFO_DEPTH.
REQ-025 ev_ready while empty SHALL have no effect.

Reset
REQ-026 When rst_n=0, at any time including mid-frame, the following SHALL hold immediately:
  - FSM=IDLE, bit index and timeout counter = 0.
  - ext=brk=0.
  - FIFO empty: ev_valid=0, ev_count=0, ev_data=0.
  - All error pulses 0.
  - Filtered clock=1, synchronizer flops=1.
REQ-027 After rst_n deassertion, the first frame SHALL be accepted normally once its start bit is sampled.

Verification
REQ-028 Frame 0x1C, odd parity=0, stop=1, ev_ready=0 -> ev_valid=1, ev_data=0x01C, ev_count=1.
REQ-029 Frames E0, F0, 74 -> a single event ev_data=0x374 is produced; no events for E0 or F0.
REQ-030 Frame 0x1C with parity=1 -> err_frame pulses once and no event is pushed. Then a frame 0x32 -> ev_data=0x032.
REQ-031 Frame stops after 4 data bits and the clock stays high for TIMEOUT_CYC cycles -> err_timeout pulses once and the FSM is IDLE. A full frame 0x15 then yields 0x015.
REQ-032 With ev_ready=0, FIFO_DEPTH+1 frames are sent -> ev_count=FIFO_DEPTH and err_ovf pulses once. Draining returns events in order.
REQ-033 1-cycle glitches on clk_kb with FILTER_LEN=4 -> no strobes and no events. rst_n is then asserted mid-frame -> all outputs return to reset values at once.
